// File: rtl/cheb_coeff_extract.sv
// cheb_coeff_extract: forward 8-point Chebyshev transform with one shared shift-add multiplier.
// Define CHEB_SAT_EN to clamp out-of-range coefficients instead of wrapping them.
module cheb_coeff_extract #(
  parameter int DW    = 16,
  parameter int GUARD = 3
) (
  input  logic                 clk30x,
  input  logic                 rst,
  input  logic signed [DW-1:0] xin,
  input  logic                 xin_valid,
  output logic                 xin_ready,
  output logic signed [DW-1:0] cout,
  output logic [2:0]           cout_idx,
  output logic                 cout_valid,
  input  logic                 cout_ready,
  output logic                 busy
);
  localparam int AW = 2*DW+GUARD;
  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;
  state_t state, state_nx;
  logic [2:0] n, k;
  logic [4:0] cnt;
  logic signed [DW-1:0] smp [8];
  logic signed [15:0] coef;
  logic signed [2*DW-1:0] mc, pp, prod;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] conv;
  logic mac_done, hs;
`ifdef CHEB_SAT_EN
  localparam logic signed [AW-1:0] MAXV = 32767;
  localparam logic signed [AW-1:0] MINV = -32768;
  logic signed [AW-1:0] scaled;
`endif

  // cos(pi*j/16) in Q1.15 for j=0..8; the rest of the circle folds onto these
  function automatic logic signed [15:0] cos_base(input logic [3:0] j);
    case (j)
      4'd0:    return 16'sd32767;
      4'd1:    return 16'sd32137;
      4'd2:    return 16'sd30273;
      4'd3:    return 16'sd27245;
      4'd4:    return 16'sd23170;
      4'd5:    return 16'sd18204;
      4'd6:    return 16'sd12539;
      4'd7:    return 16'sd6393;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] rom(input logic [2:0] kk, input logic [2:0] nn);
    logic [4:0] m, f;
    m = {2'b0, kk} * {1'b0, nn, 1'b1};
    f = m[4] ? 5'd0 - m : m;
    return f > 5'd8 ? -cos_base(4'(5'd16 - f)) : cos_base(f[3:0]);
  endfunction

  always_comb begin
    coef     = rom(k, n);
    mc       = {{DW{smp[n][DW-1]}}, smp[n]};
    pp       = coef[cnt[3:0]] ? mc <<< cnt[3:0] : '0;
    mac_done = state == MAC && cnt == 5'd16 && n == 3'd7;
    hs       = state == EMIT && cout_valid && cout_ready;
`ifdef CHEB_SAT_EN
    scaled   = (k == 3'd0) ? acc >>> 18 : acc >>> 17;
    conv     = scaled > MAXV ? 16'sh7FFF : scaled < MINV ? 16'sh8000 : scaled[DW-1:0];
`else
    conv     = DW'((k == 3'd0) ? acc >>> 18 : acc >>> 17);
`endif
    state_nx = state == IDLE ? LOAD :
               (state == LOAD && xin_valid && n == 3'd7) ? MAC :
               mac_done ? EMIT :
               hs ? (k == 3'd7 ? LOAD : MAC) : state;
  end

  always_ff @(posedge clk30x)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk30x) begin
    if (rst) begin
      n          <= '0;
      k          <= '0;
      cnt        <= '0;
      prod       <= '0;
      acc        <= '0;
      cout       <= '0;
      cout_valid <= 1'b0;
      for (int i = 0; i < 8; i++) smp[i] <= '0;
    end else begin
      case (state)
        LOAD: if (xin_valid) begin
          smp[n] <= xin;
          n      <= n + 3'd1;
          k      <= '0;
          acc    <= '0;
          cnt    <= '0;
          prod   <= '0;
        end
        // 16 shift-add steps, the sign bit of the ROM word carries negative weight
        MAC: if (cnt != 5'd16) begin
          prod <= (cnt == 5'd15) ? prod - pp : prod + pp;
          cnt  <= cnt + 5'd1;
        end else begin
          acc  <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
          prod <= '0;
          cnt  <= '0;
          n    <= n + 3'd1;
        end
        EMIT: if (!cout_valid) begin
          cout       <= conv;
          cout_valid <= 1'b1;
        end else if (cout_ready) begin
          cout_valid <= 1'b0;
          n          <= '0;
          acc        <= '0;
          k          <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign xin_ready = state == LOAD;
  assign busy      = state == MAC || state == EMIT;
  assign cout_idx  = k;
endmodule

// File: tb/tb_cheb_coeff_extract.sv
// tb_cheb_coeff_extract: directed and random blocks checked against a cosine-based model.
module tb_cheb_coeff_extract;
  logic        clk30x = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] xin = '0;
  logic        xin_valid = 1'b0;
  logic        xin_ready;
  logic [15:0] cout;
  logic [2:0]  cout_idx;
  logic        cout_valid;
  logic        cout_ready = 1'b0;
  logic        busy;
  int          n_assert = 0;
  int          n_fail = 0;
  int          smp [8];
  logic [15:0] got [8];

  cheb_coeff_extract dut (
    .clk30x(clk30x), .rst(rst), .xin(xin), .xin_valid(xin_valid), .xin_ready(xin_ready),
    .cout(cout), .cout_idx(cout_idx), .cout_valid(cout_valid), .cout_ready(cout_ready),
    .busy(busy)
  );

  always #5 clk30x = ~clk30x;

  task automatic step;
    @(posedge clk30x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rom_ref(input int k, input int n);
    real r;
    r = 32767.0 * $cos(3.141592653589793 * real'(k * (2 * n + 1)) / 16.0);
    return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
  endfunction

  function automatic logic [15:0] exp_coef(input int k);
    longint acc, sh;
    acc = 0;
    for (int n = 0; n < 8; n++) acc += longint'(smp[n]) * longint'(rom_ref(k, n));
    sh = (k == 0) ? acc >>> 18 : acc >>> 17;
`ifdef CHEB_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return 16'(sh);
  endfunction

  task automatic load_block;
    for (int i = 0; i < 8; i++) begin
      xin = 16'(smp[i]);
      xin_valid = 1'b1;
      chk("xin_ready_load", xin_ready, 1);
      step;
    end
    xin_valid = 1'b0;
  endtask

  task automatic collect(input int stall_k, input int abort_k, input bit noise);
    for (int k = 0; k < 8; k++) begin
      int waited;
      logic [15:0] held;
      bit stable;
      waited = 0;
      if (k == abort_k) begin
        repeat (20) step;
        chk("busy_mid_mac", busy, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_cout", cout, 0);
        chk("abort_valid", cout_valid, 0);
        chk("abort_idx", cout_idx, 0);
        chk("abort_xin_ready", xin_ready, 0);
        chk("abort_busy", busy, 0);
        step;
        chk("reload_ready", xin_ready, 1);
        return;
      end
      while (!cout_valid && waited < 400) begin
        if (noise) begin
          xin_valid = 1'b1;
          xin = 16'h1234;
          cout_ready = 1'b1;
        end
        step;
        waited++;
      end
      xin_valid = 1'b0;
      cout_ready = 1'b0;
      chk("latency", waited, 137);
      chk("coef", cout, exp_coef(k));
      chk("coef_idx", cout_idx, k);
      chk("ready_vs_valid", xin_ready, 0);
      chk("busy_emit", busy, 1);
      if (k == stall_k) begin
        held = cout;
        stable = 1'b1;
        repeat (50) begin
          step;
          if (cout !== held || cout_idx !== 3'(k) || !cout_valid || xin_ready) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
      end
      got[k] = cout;
      cout_ready = 1'b1;
      step;
      cout_ready = 1'b0;
      chk("valid_drop", cout_valid, 0);
    end
    chk("back_to_load", xin_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic check_t1;
    for (int i = 0; i < 8; i++) chk("t1_coef", got[i], (i == 0) ? 16'h3FFF : 16'h0000);
  endtask

  task automatic fill_t1;
    for (int i = 0; i < 8; i++) smp[i] = 16384;
  endtask

  initial begin
    repeat (3) step;
    chk("rst_xin_ready", xin_ready, 0);
    chk("rst_cout", cout, 0);
    chk("rst_idx", cout_idx, 0);
    chk("rst_valid", cout_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step;
    chk("load_after_rst", xin_ready, 1);
    chk("load_busy", busy, 0);

    fill_t1;
    load_block;
    collect(-1, -1, 1'b0);
    check_t1;

    smp = '{32767, 0, 0, 0, 0, 0, 0, 0};
    load_block;
    collect(-1, -1, 1'b0);
    chk("t2_c0", got[0], 4095);
    chk("t2_c1", got[1], 8034);

    smp = '{32767, 32767, 32767, 32767, -32767, -32767, -32767, -32767};
    load_block;
    collect(-1, -1, 1'b0);
`ifdef CHEB_SAT_EN
    chk("t3_c1_sat", got[1], 16'h7FFF);
`else
    chk("t3_c1_wrap_sign", got[1][15], 1);
`endif

    for (int i = 0; i < 8; i++) smp[i] = -32768;
    load_block;
    collect(-1, -1, 1'b0);

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        logic [15:0] r;
        r = 16'($urandom);
        smp[i] = int'($signed(r));
      end
      load_block;
      collect((b == 0) ? 2 : -1, -1, 1'b0);
    end

    fill_t1;
    load_block;
    collect(-1, 4, 1'b0);
    load_block;
    collect(-1, -1, 1'b0);
    check_t1;

    load_block;
    collect(-1, -1, 1'b1);
    check_t1;
    load_block;
    collect(-1, -1, 1'b0);
    check_t1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
